// File: rtl/decode_mc_if.sv
// Instruction-field / control-output bundle between the IR, the multicycle
// decoder and the datapath muxes and enables.
interface decode_mc_if #(
   parameter int ALUCTRL_W = 3
);
   logic [1:0]           Op;
   logic [5:0]           Funct;
   logic [3:0]           Rd;
   logic                 IsMul;
   logic                 MemReady;
   logic                 PCWrite;
   logic                 IRWrite;
   logic                 RegW;
   logic                 MemW;
   logic                 AdrSrc;
   logic [1:0]           ResultSrc;
   logic [1:0]           ALUSrcA;
   logic [1:0]           ALUSrcB;
   logic [1:0]           ImmSrc;
   logic [1:0]           RegSrc;
   logic [ALUCTRL_W-1:0] ALUControl;
   logic [1:0]           FlagW;
   logic                 MulStart;
   logic                 Illegal;
   logic [3:0]           State;

   modport master (
      output Op, Funct, Rd, IsMul, MemReady,
      input  PCWrite, IRWrite, RegW, MemW, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, RegSrc, ALUControl, FlagW, MulStart, Illegal, State
   );

   modport slave (
      input  Op, Funct, Rd, IsMul, MemReady,
      output PCWrite, IRWrite, RegW, MemW, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, RegSrc, ALUControl, FlagW, MulStart, Illegal, State
   );
endinterface

// File: rtl/decode_mc.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder, PC logic and
// instruction decoder, with memory-ready stalls and a multi-cycle multiply.
module decode_mc #(
   parameter int ALUCTRL_W   = 3,
   parameter int MUL_LATENCY = 4,
   parameter int ENABLE_MUL  = 1
) (
   input  logic       clk,
   input  logic       reset,
   decode_mc_if.slave bus
);
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,  S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,  S_EXECUTEI = 4'd7,  S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,  S_MULWAIT  = 4'd10
   } state_t;

   localparam logic [3:0] LP_MUL_LOAD = 4'(MUL_LATENCY - 1);

   state_t               r_state, w_next;
   logic [3:0]           r_cnt;
   logic                 r_nowrite, r_mulpath;
   logic                 w_nextpc, w_irw, w_regw, w_memw, w_adr, w_aluop;
   logic                 w_branch, w_ms, w_ill, w_nw, w_pcs;
   logic [1:0]           w_res, w_sa, w_sb, w_fw;
   logic [2:0]           w_alu3;
   logic [ALUCTRL_W-1:0] w_aluctrl;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_FETCH;
         r_cnt     <= '0;
         r_nowrite <= 1'b0;
         r_mulpath <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE && w_next == S_MULWAIT)
            r_cnt <= LP_MUL_LOAD;
         else if (r_state == S_MULWAIT && r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
         if (r_state == S_FETCH)
            r_nowrite <= 1'b0;
         else if (r_state == S_EXECUTER || r_state == S_EXECUTEI)
            r_nowrite <= w_nw;
         // ALUWB picks MulResult only when entered straight from MULWAIT
         r_mulpath <= (r_state == S_MULWAIT) && (r_cnt == 4'd0);
      end
   end

   always_comb begin
      w_next   = r_state;
      w_nextpc = 1'b0;
      w_irw    = 1'b0;
      w_regw   = 1'b0;
      w_memw   = 1'b0;
      w_adr    = 1'b0;
      w_res    = 2'b00;
      w_sa     = 2'b00;
      w_sb     = 2'b00;
      w_aluop  = 1'b0;
      w_branch = 1'b0;
      w_ms     = 1'b0;
      w_ill    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_sa     = 2'b01;
            w_sb     = 2'b10;
            w_res    = 2'b10;
            w_irw    = bus.MemReady;
            w_nextpc = bus.MemReady;
            if (bus.MemReady) w_next = S_DECODE;
         end
         S_DECODE: begin
            w_sa  = 2'b01;
            w_sb  = 2'b10;
            w_res = 2'b10;
            case (bus.Op)
               2'b01: w_next = S_MEMADR;
               2'b10: w_next = S_BRANCH;
               2'b00: begin
                  if (bus.Funct[5])                      w_next = S_EXECUTEI;
                  else if (bus.IsMul && ENABLE_MUL != 0) w_next = S_MULWAIT;
                  else                                   w_next = S_EXECUTER;
               end
               default: begin
                  w_next = S_FETCH;
                  w_ill  = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            w_sb   = 2'b01;
            w_next = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_adr = 1'b1;
            if (bus.MemReady) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_res  = 2'b01;
            w_regw = 1'b1;
            w_next = S_FETCH;
         end
         S_MEMWRITE: begin
            w_adr  = 1'b1;
            w_memw = bus.MemReady;
            if (bus.MemReady) w_next = S_FETCH;
         end
         S_EXECUTER: begin
            w_aluop = 1'b1;
            w_next  = S_ALUWB;
         end
         S_EXECUTEI: begin
            w_sb    = 2'b01;
            w_aluop = 1'b1;
            w_next  = S_ALUWB;
         end
         S_MULWAIT: begin
            w_ms = (r_cnt == LP_MUL_LOAD);
            if (r_cnt == 4'd0) w_next = S_ALUWB;
         end
         S_ALUWB: begin
            w_res  = r_mulpath ? 2'b11 : 2'b00;
            w_regw = !r_nowrite;
            w_next = S_FETCH;
         end
         S_BRANCH: begin
            w_sa     = 2'b10;
            w_sb     = 2'b01;
            w_res    = 2'b10;
            w_branch = 1'b1;
            w_next   = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
      // reset abandons the instruction: no enables, FETCH mux settings
      if (!reset) begin
         w_nextpc = 1'b0;
         w_irw    = 1'b0;
         w_regw   = 1'b0;
         w_memw   = 1'b0;
         w_branch = 1'b0;
         w_ms     = 1'b0;
         w_ill    = 1'b0;
         w_aluop  = 1'b0;
         w_adr    = 1'b0;
         w_sa     = 2'b01;
         w_sb     = 2'b10;
         w_res    = 2'b10;
      end
   end

   always_comb begin
      w_alu3 = 3'b000;
      w_fw   = 2'b00;
      w_nw   = 1'b0;
      if (w_aluop) begin
         case (bus.Funct[4:1])
            4'b0100: begin w_alu3 = 3'b000; w_fw = {2{bus.Funct[0]}}; end
            4'b0010: begin w_alu3 = 3'b001; w_fw = {2{bus.Funct[0]}}; end
            4'b0000: begin w_alu3 = 3'b010; w_fw = {bus.Funct[0], 1'b0}; end
            4'b1100: begin w_alu3 = 3'b011; w_fw = {bus.Funct[0], 1'b0}; end
            4'b0001: begin w_alu3 = 3'b100; w_fw = {bus.Funct[0], 1'b0}; end
            4'b1101: begin w_alu3 = 3'b101; w_fw = {bus.Funct[0], 1'b0}; end
            4'b1010: begin w_alu3 = 3'b001; w_fw = {1'b1, bus.Funct[0]}; w_nw = 1'b1; end
            4'b1000: begin w_alu3 = 3'b010; w_fw = 2'b10; w_nw = 1'b1; end
            default: ;
         endcase
      end
      w_aluctrl      = '0;
      w_aluctrl[2:0] = w_alu3;
   end

   assign w_pcs = ((bus.Rd == 4'hF) && w_regw) || w_branch;

   assign bus.PCWrite    = w_nextpc | w_pcs;
   assign bus.IRWrite    = w_irw;
   assign bus.RegW       = w_regw;
   assign bus.MemW       = w_memw;
   assign bus.AdrSrc     = w_adr;
   assign bus.ResultSrc  = w_res;
   assign bus.ALUSrcA    = w_sa;
   assign bus.ALUSrcB    = w_sb;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
   assign bus.ALUControl = w_aluctrl;
   assign bus.FlagW      = w_fw;
   assign bus.MulStart   = w_ms;
   assign bus.Illegal    = w_ill;
   assign bus.State      = r_state;
endmodule

// File: tb/tb_decode_mc.sv
// Scoreboard bench for decode_mc: per-cycle expected control words are queued
// with their stimulus and compared against the DUT on the falling edge.
module tb_decode_mc;
   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, regw, memw, adr;
      logic [1:0] res, sa, sb, imm, rsrc;
      logic [2:0] alu;
      logic [1:0] fw;
      logic       ms, ill;
   } o_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] op = 2'b00;
   logic [5:0] funct = '0;
   logic [3:0] rd = '0;
   logic       ismul = 1'b0;
   logic       mr_a = 1'b0, mr_b = 1'b0;
   int         n_chk = 0, n_fail = 0;
   o_t         exp_q[$];
   logic       mr_q[$];
   logic       rs_q[$];

   decode_mc_if #(.ALUCTRL_W(3)) ifa ();
   decode_mc_if #(.ALUCTRL_W(3)) ifb ();

   assign ifa.Op = op;  assign ifa.Funct = funct;  assign ifa.Rd = rd;
   assign ifa.IsMul = ismul;  assign ifa.MemReady = mr_a;
   assign ifb.Op = op;  assign ifb.Funct = funct;  assign ifb.Rd = rd;
   assign ifb.IsMul = ismul;  assign ifb.MemReady = mr_b;

   decode_mc #(.ALUCTRL_W(3), .MUL_LATENCY(4), .ENABLE_MUL(1)) dut_a (
      .clk(clk), .reset(rst), .bus(ifa));
   decode_mc #(.ALUCTRL_W(3), .MUL_LATENCY(4), .ENABLE_MUL(0)) dut_b (
      .clk(clk), .reset(rst), .bus(ifb));

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic o_t smp(bit b);
      if (b) return {ifb.State, ifb.PCWrite, ifb.IRWrite, ifb.RegW, ifb.MemW, ifb.AdrSrc,
                     ifb.ResultSrc, ifb.ALUSrcA, ifb.ALUSrcB, ifb.ImmSrc, ifb.RegSrc,
                     ifb.ALUControl, ifb.FlagW, ifb.MulStart, ifb.Illegal};
      return {ifa.State, ifa.PCWrite, ifa.IRWrite, ifa.RegW, ifa.MemW, ifa.AdrSrc,
              ifa.ResultSrc, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ImmSrc, ifa.RegSrc,
              ifa.ALUControl, ifa.FlagW, ifa.MulStart, ifa.Illegal};
   endfunction

   // Expected word for a state: per-state mux values, enables {pcw,irw,regw,memw}
   function automatic o_t ex(int st, logic [3:0] en);
      o_t o = '0;
      o.st   = 4'(st);
      o.imm  = op;
      o.rsrc = {op == 2'b01, op == 2'b10};
      {o.pcw, o.irw, o.regw, o.memw} = en;
      case (st)
         0, 1: begin o.sa = 2'b01; o.sb = 2'b10; o.res = 2'b10; end
         2, 7: o.sb = 2'b01;
         3, 5: o.adr = 1'b1;
         4:    o.res = 2'b01;
         9:    begin o.sa = 2'b10; o.sb = 2'b01; o.res = 2'b10; end
         default: ;
      endcase
      return o;
   endfunction

   task automatic push(o_t e, logic m, logic r);
      exp_q.push_back(e);
      mr_q.push_back(m);
      rs_q.push_back(r);
   endtask

   task automatic test_reset();
      o_t e, g;
      op = 2'b00; funct = '0; rd = '0; ismul = 1'b0;
      push(ex(0, 4'b0000), 1'b1, 1'b0);
      push(ex(0, 4'b0000), 1'b1, 1'b0);
      push(ex(0, 4'b0000), 1'b0, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); mr_a = mr_q.pop_front(); rst = rs_q.pop_front();
         @(negedge clk); g = smp(0); n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL reset got=%h exp=%h", g, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_add();
      o_t e, g;
      op = 2'b00; funct = 6'b001000; rd = 4'd1; ismul = 1'b0;
      push(ex(0, 4'b1100), 1'b1, 1'b1);
      push(ex(1, 4'b0000), 1'b1, 1'b1);
      push(ex(6, 4'b0000), 1'b1, 1'b1);
      push(ex(8, 4'b0010), 1'b1, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); mr_a = mr_q.pop_front(); rst = rs_q.pop_front();
         @(negedge clk); g = smp(0); n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL add st=%0d got=%h exp=%h", e.st, g, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_stall();
      o_t e, g;
      for (int k = 0; k < 2; k++) begin
         op = 2'b01; rd = 4'd2; ismul = 1'b0;
         if (k == 0) begin
            funct = 6'b011001;
            push(ex(0, 4'b0000), 1'b0, 1'b1);
            push(ex(0, 4'b0000), 1'b0, 1'b1);
            push(ex(0, 4'b1100), 1'b1, 1'b1);
            push(ex(1, 4'b0000), 1'b1, 1'b1);
            push(ex(2, 4'b0000), 1'b1, 1'b1);
            for (int i = 0; i < 3; i++) push(ex(3, 4'b0000), 1'b0, 1'b1);
            push(ex(3, 4'b0000), 1'b1, 1'b1);
            push(ex(4, 4'b0010), 1'b1, 1'b1);
         end else begin
            funct = 6'b011000;
            push(ex(0, 4'b1100), 1'b1, 1'b1);
            push(ex(1, 4'b0000), 1'b1, 1'b1);
            push(ex(2, 4'b0000), 1'b1, 1'b1);
            push(ex(5, 4'b0000), 1'b0, 1'b1);
            push(ex(5, 4'b0001), 1'b1, 1'b1);
         end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); mr_a = mr_q.pop_front(); rst = rs_q.pop_front();
            @(negedge clk); g = smp(0); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL mem_stall%0d st=%0d got=%h exp=%h", k, e.st, g, e); end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_back_to_back();
      o_t e, g;
      for (int k = 0; k < 2; k++) begin
         ismul = 1'b0;
         if (k == 0) begin
            op = 2'b01; funct = 6'b011000; rd = 4'd4;
            push(ex(0, 4'b1100), 1'b1, 1'b1);
            push(ex(1, 4'b0000), 1'b1, 1'b1);
            push(ex(2, 4'b0000), 1'b1, 1'b1);
            push(ex(5, 4'b0001), 1'b1, 1'b1);
         end else begin
            op = 2'b10; funct = 6'b100000; rd = 4'd0;
            push(ex(0, 4'b1100), 1'b1, 1'b1);
            push(ex(1, 4'b0000), 1'b1, 1'b1);
            push(ex(9, 4'b1000), 1'b1, 1'b1);
         end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); mr_a = mr_q.pop_front(); rst = rs_q.pop_front();
            @(negedge clk); g = smp(0); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL str_b%0d st=%0d got=%h exp=%h", k, e.st, g, e); end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_mul();
      o_t e, g;
      op = 2'b00; funct = 6'b000000; rd = 4'd3; ismul = 1'b1;
      push(ex(0, 4'b1100), 1'b1, 1'b1);
      push(ex(1, 4'b0000), 1'b1, 1'b1);
      e = ex(10, 4'b0000); e.ms = 1'b1;
      push(e, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) push(ex(10, 4'b0000), 1'b1, 1'b1);
      e = ex(8, 4'b0010); e.res = 2'b11;
      push(e, 1'b1, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); mr_a = mr_q.pop_front(); rst = rs_q.pop_front();
         @(negedge clk); g = smp(0); n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL mul st=%0d got=%h exp=%h", e.st, g, e); end
         @(posedge clk); #1;
      end
      ismul = 1'b0;
   endtask

   task automatic test_mul_disabled();
      o_t e, g;
      op = 2'b00; funct = 6'b000000; rd = 4'd3; ismul = 1'b1; mr_a = 1'b0;
      push(ex(0, 4'b1100), 1'b1, 1'b1);
      push(ex(1, 4'b0000), 1'b1, 1'b1);
      e = ex(6, 4'b0000); e.alu = 3'b010;
      push(e, 1'b1, 1'b1);
      push(ex(8, 4'b0010), 1'b0, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); mr_b = mr_q.pop_front(); rst = rs_q.pop_front();
         @(negedge clk); g = smp(1); n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL mul_disabled st=%0d got=%h exp=%h", e.st, g, e); end
         @(posedge clk); #1;
      end
      mr_b = 1'b0; ismul = 1'b0;
   endtask

   // ALU decode table: funct, ALUControl, FlagW, RegW in ALUWB
   task automatic test_alu();
      o_t e, g;
      logic [5:0] fn [10] = '{6'b010101, 6'b001000, 6'b000101, 6'b011000, 6'b000011,
                              6'b111011, 6'b010001, 6'b000111, 6'b100001, 6'b110100};
      logic [2:0] al [10] = '{3'b001, 3'b000, 3'b001, 3'b011, 3'b100,
                              3'b101, 3'b010, 3'b000, 3'b010, 3'b001};
      logic [1:0] fwv [10] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b10,
                               2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
      logic       wr [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 10; k++) begin
         op = 2'b00; funct = fn[k]; rd = 4'd1; ismul = 1'b0;
         push(ex(0, 4'b1100), 1'b1, 1'b1);
         push(ex(1, 4'b0000), 1'b1, 1'b1);
         e = ex(fn[k][5] ? 7 : 6, 4'b0000); e.alu = al[k]; e.fw = fwv[k];
         push(e, 1'b1, 1'b1);
         push(ex(8, {2'b00, wr[k], 1'b0}), 1'b1, 1'b1);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); mr_a = mr_q.pop_front(); rst = rs_q.pop_front();
            @(negedge clk); g = smp(0); n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL alu%0d funct=%b st=%0d got=%h exp=%h", k, fn[k], e.st, g, e); end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_rd15();
      o_t e, g;
      op = 2'b00; funct = 6'b001000; rd = 4'hF; ismul = 1'b0;
      push(ex(0, 4'b1100), 1'b1, 1'b1);
      push(ex(1, 4'b0000), 1'b1, 1'b1);
      push(ex(6, 4'b0000), 1'b1, 1'b1);
      push(ex(8, 4'b1010), 1'b1, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); mr_a = mr_q.pop_front(); rst = rs_q.pop_front();
         @(negedge clk); g = smp(0); n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL rd15 st=%0d got=%h exp=%h", e.st, g, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      o_t e, g;
      op = 2'b01; funct = 6'b011000; rd = 4'd5; ismul = 1'b0;
      push(ex(0, 4'b1100), 1'b1, 1'b1);
      push(ex(1, 4'b0000), 1'b1, 1'b1);
      push(ex(2, 4'b0000), 1'b1, 1'b1);
      e = ex(0, 4'b0000); e.st = 4'd5;
      push(e, 1'b1, 1'b0);
      push(ex(0, 4'b1100), 1'b1, 1'b1);
      push(ex(1, 4'b0000), 1'b1, 1'b1);
      push(ex(2, 4'b0000), 1'b1, 1'b1);
      push(ex(5, 4'b0001), 1'b1, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); mr_a = mr_q.pop_front(); rst = rs_q.pop_front();
         @(negedge clk); g = smp(0); n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL reset_mid st=%0d got=%h exp=%h", e.st, g, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      o_t e, g;
      op = 2'b11; funct = 6'b000000; rd = 4'd0; ismul = 1'b0;
      push(ex(0, 4'b1100), 1'b1, 1'b1);
      e = ex(1, 4'b0000); e.ill = 1'b1;
      push(e, 1'b1, 1'b1);
      push(ex(0, 4'b0000), 1'b0, 1'b1);
      push(ex(0, 4'b0000), 1'b0, 1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); mr_a = mr_q.pop_front(); rst = rs_q.pop_front();
         @(negedge clk); g = smp(0); n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL illegal st=%0d got=%h exp=%h", e.st, g, e); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_add();
      test_mem_stall();
      test_back_to_back();
      test_mul();
      test_mul_disabled();
      test_alu();
      test_rd15();
      test_reset_mid();
      test_illegal();
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule

// File: doc/decode_mc.md
Name: decode_mc

Overview:
- Parameterised multicycle control unit for the ARM-subset datapath, with the main FSM folded in.
- Combines the main FSM, ALU decoder, PC logic and instruction decoder in one block.
- Adds over the previous decoder:
  - a memory-ready handshake that stalls the fetch and memory states;
  - a multi-cycle multiply state with a configurable latency;
  - CMP, TST and MOV decoding;
  - an illegal-instruction indication.
- Sits between the instruction register fields and the datapath mux/enable inputs.

Parameters:
- ALUCTRL_W, 3: width of ALUControl; must be ≥3; bits above [2] are driven 0.
- MUL_LATENCY, 4: cycles spent in MULWAIT; legal range 1..15.
- ENABLE_MUL, 1: 0 disables multiply; a multiply then decodes as EXECUTER.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-low reset
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- IsMul  in  1  Instr[7:4]==4'b1001 with Op==00, Funct[5]==0
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- RegW  out  1  register-file write enable
- MemW  out  1  data-memory write enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult, 11 MulResult
- ALUSrcA  out  2  ALU A select: 00 = Rn, 01 = PC, 10 = ALUOut
- ALUSrcB  out  2  ALU B select: 00 = Rm, 01 = ExtImm, 10 = constant 4
- ImmSrc  out  2  equal to Op
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
- ALUControl  out  ALUCTRL_W  ALU operation code
- FlagW  out  2  flag write enables: [1] = NZ, [0] = CV
- MulStart  out  1  one-cycle pulse on entry to MULWAIT
- Illegal  out  1  one-cycle pulse in DECODE when Op==11
- State  out  4  current FSM state encoding, for debug

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, MULWAIT=10
- Reset (reset==0 at a rising edge):
  - state←FETCH, mul counter←0, latched no-write flag←0.
  - While reset is low, IRWrite, PCWrite, RegW, MemW, MulStart and Illegal are forced 0.
  - Mux selects take their FETCH values while reset is low.
  - A reset asserted mid-instruction abandons that instruction; no write enable is asserted in that cycle.
- Default output value in any state, unless listed for that state: 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - IRWrite and NextPC equal MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=00 with Funct[5]=1 → EXECUTEI.
  - Op=00 with Funct[5]=0, IsMul=1 and ENABLE_MUL=1 → MULWAIT.
  - Any other Op=00 → EXECUTER.
  - Op=11 → FETCH, with Illegal=1 for this cycle.
- MEMADR:
  - ALUSrcA=00, ALUSrcB=01.
  - Funct[0]=1 → MEMREAD; Funct[0]=0 → MEMWRITE.
- MEMREAD:
  - AdrSrc=1, ResultSrc=00.
  - Hold until MemReady=1, then → MEMWB.
- MEMWB: ResultSrc=01, RegW=1 → FETCH.
- MEMWRITE:
  - AdrSrc=1, MemW=MemReady.
  - Hold until MemReady=1, then → FETCH.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1 → ALUWB.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1 → ALUWB.
- MULWAIT:
  - Counter loads MUL_LATENCY-1 on entry; MulStart pulses in the entry cycle only.
  - Counter decrements each cycle; at 0 → ALUWB with the multiply path flagged.
  - Total cycles spent in MULWAIT = MUL_LATENCY.
- ALUWB:
  - ResultSrc=11 if reached from MULWAIT, else 00.
  - RegW=1 unless the no-write flag is set (CMP or TST).
  - → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1 → FETCH.
- ALU decoder (active when ALUOp=1), case on Funct[4:1]:
  - 0100 ADD → 000
  - 0010 SUB → 001
  - 0000 AND → 010
  - 1100 ORR → 011
  - 0001 EOR → 100
  - 1101 MOV → 101
  - 1010 CMP → 001, sets the no-write flag
  - 1000 TST → 010, sets the no-write flag
  - Any other code → 000, FlagW=00.
- ALU decoder, flag enables:
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (ADD | SUB | CMP).
  - CMP and TST force FlagW[1]=1 regardless of Funct[0].
- ALU decoder, inactive (ALUOp=0): ALUControl=0, FlagW=00.
- No-write flag:
  - Registered in EXECUTER and EXECUTEI.
  - Cleared in FETCH and on reset.
- PC logic:
  - PCS = (Rd==4'hF & RegW) | Branch.
  - PCWrite = NextPC | PCS.
  - This is combinational in the same cycle as RegW.

Test Plan:
- ADD R1,R2,R3 with S=0 and MemReady=1:
  - States 0→1→6→8→0 over 4 cycles.
  - RegW=1 only in cycle 4, ALUControl=000, FlagW=00.
- LDR (Funct[0]=1), MemReady low for 2 cycles in FETCH and 3 cycles in MEMREAD:
  - IRWrite pulses once, in the ready cycle.
  - RegW with ResultSrc=01 only in MEMWB.
  - Total 5+2+3 = 10 cycles.
- STR, then B, back-to-back with MemReady=1:
  - STR takes 4 cycles, MemW=1 only in MEMWRITE.
  - B takes 3 cycles; Branch=1 and PCWrite=1 in BRANCH.
- MUL with MUL_LATENCY=4:
  - MulStart pulses exactly once.
  - 4 cycles in state 10, then ALUWB with ResultSrc=11 and RegW=1; 7 cycles total.
  - Repeat with ENABLE_MUL=0: the instruction follows the EXECUTER path.
- CMP with Funct=6'b010101:
  - ALUControl=001, FlagW=11, RegW=0 in ALUWB.
  - A following ADD with S=0 gets RegW=1 (no-write flag cleared).
- ADD with Rd=15:
  - PCWrite=1 in ALUWB.
- Reset:
  - reset=0 during MEMWRITE with MemReady=1: MemW=0; the next cycle with reset=1 is FETCH.
- Illegal instruction:
  - Op=11 gives Illegal=1 for 1 cycle, then FETCH.
